// File: rtl/tiny_dnn_pkg.sv
// Shared types, constants and helpers for the tiny-dnn multi-channel MAC core.
package tiny_dnn_pkg;

  localparam int unsigned F_SIZE = 1024;
  localparam int unsigned N_CH   = 4;
  localparam int unsigned DW     = 16;
  localparam int unsigned FRAC   = 8;
  localparam int unsigned AW     = 40;

  localparam int unsigned AD_W = $clog2(F_SIZE);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef logic signed [DW-1:0] data_t;
  typedef logic signed [AW-1:0] acc_t;
  typedef logic [AD_W-1:0]      adr_t;

  localparam adr_t BIAS_ADR = adr_t'(F_SIZE - 1);

  localparam acc_t SAT_HI = (acc_t'(1) <<< DW - 1) - acc_t'(1);
  localparam acc_t SAT_LO = -SAT_HI - acc_t'(1);

  // Clamp an accumulator-width value into the signed DW-bit result range
  function automatic data_t sat_dw(acc_t v);
    if (v > SAT_HI)      return data_t'(SAT_HI);
    else if (v < SAT_LO) return data_t'(SAT_LO);
    else                 return data_t'(v);
  endfunction

  function automatic acc_t relu(acc_t v);
    return v[AW-1] ? '0 : v;
  endfunction

endpackage

// File: rtl/tiny_dnn_lane.sv
// One MAC lane: private weight RAM with bias slot, weight register, accumulator
// and rescale/saturate output register.
module tiny_dnn_lane
  import tiny_dnn_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  we,
  input  adr_t  adr,
  input  data_t wd,
  input  logic  init,
  input  logic  exec1,
  input  logic  bias1,
  input  data_t d1,
  input  logic  fin2,
  input  logic  relu2,
  output data_t sum
);

  data_t                 mem [F_SIZE];
  data_t                 w;
  acc_t                  acc;
  acc_t                  term;
  acc_t                  res;
  logic                  has_term;
  logic signed [2*DW-1:0] prod;

  // Weight RAM is deliberately not reset
  always_ff @(posedge clk) begin
    if (we) mem[adr] <= wd;
  end

  // Read-before-write: a same-cycle write to adr is not visible here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) w <= '0;
    else     w <= mem[adr];
  end

  // Bias is pre-scaled to product alignment and takes priority over exec
  always_comb begin
    prod     = w * d1;
    has_term = exec1 | bias1;
    term     = '0;
    if (bias1)      term = acc_t'(w) <<< FRAC;
    else if (exec1) term = acc_t'(prod);
    res = relu2 ? relu(acc) : acc;
    res = res >>> FRAC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           acc <= '0;
    else if (init)     acc <= has_term ? term : '0;
    else if (has_term) acc <= acc + term;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       sum <= '0;
    else if (fin2) sum <= sat_dw(res);
  end

endmodule

// File: rtl/tiny_dnn_core_mc.sv
// Multi-channel fixed-point MAC core: N_CH lanes share one streamed feature and
// each produces one saturated neuron output per pass.
module tiny_dnn_core_mc
  import tiny_dnn_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init,
  input  logic                   write,
  input  logic                   bwrite,
  input  logic [CH_W-1:0]        wch,
  input  logic                   exec,
  input  logic                   bias,
  input  logic [AD_W-1:0]        a,
  input  logic signed [DW-1:0]   d,
  input  logic signed [DW-1:0]   wd,
  input  logic                   fin,
  input  logic                   relu,
  output logic [N_CH*DW-1:0]     sum,
  output logic                   out_valid
);

  adr_t  adr_c;
  data_t d1;
  logic  exec1, bias1, fin1, fin2, relu1, relu2;
  data_t lane_sum [N_CH];

  assign adr_c = (bwrite | bias) ? BIAS_ADR : adr_t'(a);

  // Control pipeline: stage 1 aligns with the weight read, stage 2 with the accumulate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1        <= '0;
      exec1     <= 1'b0;
      bias1     <= 1'b0;
      fin1      <= 1'b0;
      fin2      <= 1'b0;
      relu1     <= 1'b0;
      relu2     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      d1        <= d;
      exec1     <= exec;
      bias1     <= bias;
      fin1      <= fin;
      fin2      <= fin1;
      relu1     <= relu;
      relu2     <= relu1;
      out_valid <= fin2;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    tiny_dnn_lane u_lane (
      .clk   (clk),
      .rst   (rst),
      .we    (write && (wch == CH_W'(i))),
      .adr   (adr_c),
      .wd    (wd),
      .init  (init),
      .exec1 (exec1),
      .bias1 (bias1),
      .d1    (d1),
      .fin2  (fin2),
      .relu2 (relu2),
      .sum   (lane_sum[i])
    );
    assign sum[i*DW +: DW] = lane_sum[i];
  end

endmodule

// File: tb/tb_tiny_dnn_core_mc.sv
// Directed bench for tiny_dnn_core_mc with hand-computed expected results.
module tb_tiny_dnn_core_mc;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               init = 1'b0, write = 1'b0, bwrite = 1'b0;
  logic               exec = 1'b0, bias = 1'b0, fin = 1'b0, relu = 1'b0;
  logic [1:0]         wch = '0;
  logic [9:0]         a = '0;
  logic signed [15:0] d = '0, wd = '0;
  logic [63:0]        sum;
  logic               out_valid;

  int n_vec = 0;
  int n_err = 0;

  tiny_dnn_core_mc dut (
    .clk       (clk),
    .rst       (rst),
    .init      (init),
    .write     (write),
    .bwrite    (bwrite),
    .wch       (wch),
    .exec      (exec),
    .bias      (bias),
    .a         (a),
    .d         (d),
    .wd        (wd),
    .fin       (fin),
    .relu      (relu),
    .sum       (sum),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [63:0] lane(input int i);
    logic signed [15:0] v;
    v = sum[i*16 +: 16];
    return 64'(v);
  endfunction

  task automatic idle();
    init = 0; write = 0; bwrite = 0; exec = 0; bias = 0; fin = 0; relu = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input int ch, input int adr, input logic signed [15:0] val, input logic isbias);
    write = 1; bwrite = isbias; wch = 2'(ch); a = 10'(adr); wd = val;
    step();
  endtask

  // Consumes the caller's fin cycle and checks the 3-cycle latency
  task automatic result(input string tag);
    step();
    step();
    check({tag, "_lat"}, 64'(out_valid), 64'd0);
    step();
    check({tag, "_vld"}, 64'(out_valid), 64'd1);
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_sum", sum, 64'd0);
    rst = 0;

    for (int ch = 0; ch < 4; ch++)
      for (int ad = 0; ad < 1024; ad++)
        wr(ch, ad, 16'sd0, 1'b0);

    // 1: two MACs on lane 0, fin with the last exec
    wr(0, 0, 16'sd256, 1'b0);
    wr(0, 1, 16'sd512, 1'b0);
    init = 1; step();
    exec = 1; a = 0; d = 16'sd256; step();
    exec = 1; a = 1; d = 16'sd128; fin = 1;
    result("t1");
    check("t1_l0", lane(0), 64'sd512);
    check("t1_l1", lane(1), 64'sd0);
    check("t1_l2", lane(2), 64'sd0);
    check("t1_l3", lane(3), 64'sd0);
    step();
    check("t1_pulse", 64'(out_valid), 64'd0);

    // 2: negative bias on lane 1, without and with relu
    wr(1, 0, -16'sd128, 1'b1);
    init = 1; step();
    bias = 1; step();
    fin = 1; relu = 0;
    result("t2a");
    check("t2a_l1", lane(1), -64'sd128);
    check("t2a_l0", lane(0), 64'sd0);
    fin = 1; relu = 1;
    result("t2b");
    check("t2b_l1", lane(1), 64'sd0);

    // 3: saturation both ways on lane 2
    wr(2, 2, 16'sh7FFF, 1'b0);
    init = 1; step();
    repeat (4) begin exec = 1; a = 2; d = 16'sh7FFF; step(); end
    fin = 1;
    result("t3a");
    check("t3a_l2", lane(2), 64'sd32767);
    check("t3a_l0", lane(0), 64'sd0);
    init = 1; step();
    repeat (4) begin exec = 1; a = 2; d = 16'sh8000; step(); end
    fin = 1;
    result("t3b");
    check("t3b_l2", lane(2), -64'sd32768);

    // 4a: init merges with the in-flight term; older terms are dropped
    init = 1; step();
    exec = 1; a = 1; d = 16'sd512; step();
    exec = 1; a = 0; d = 16'sd256; step();
    init = 1; fin = 1;
    result("t4a");
    check("t4a_l0", lane(0), 64'sd256);
    // 4b: exec+bias together adds only the bias
    init = 1; step();
    exec = 1; bias = 1; a = 0; d = 16'sd256; step();
    fin = 1;
    result("t4b");
    check("t4b_l0", lane(0), 64'sd0);
    check("t4b_l1", lane(1), -64'sd128);

    // 5a: a write to lane 2 only affects lane 2
    wr(2, 5, 16'sd512, 1'b0);
    init = 1; step();
    exec = 1; a = 5; d = 16'sd256; fin = 1;
    result("t5a");
    check("t5a_l2", lane(2), 64'sd512);
    check("t5a_l0", lane(0), 64'sd0);
    check("t5a_l1", lane(1), 64'sd0);
    check("t5a_l3", lane(3), 64'sd0);
    // 5b: same-cycle write+exec reads the old weight
    init = 1; step();
    write = 1; wch = 3; a = 6; wd = 16'sd256; exec = 1; d = 16'sd256; step();
    exec = 1; a = 6; d = 16'sd256; fin = 1;
    result("t5b");
    check("t5b_l3", lane(3), 64'sd256);
    check("t5b_l2", lane(2), 64'sd0);

    // 6: reset between fin and its pulse
    init = 1; step();
    exec = 1; a = 0; d = 16'sd256; step();
    fin = 1; step();
    #2 rst = 1;
    #1;
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_sum", sum, 64'd0);
    @(posedge clk);
    #1 rst = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t6_nopulse", 64'(out_valid), 64'd0);
    end
    check("t6_sum_hold", sum, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
